exposure_sequencer: RTL and testbench

- Sequences one camera exposure: open shutter, run the exposure timer, close shutter, hand off to sensor readout.
- Sits directly upstream of the exposure timer and drives its `load`/`preset` inputs.
- Consumes the timer's `done` to end the exposure.
- Fronts the readout engine with a req/ack handshake.

---
 rtl/exposure_sequencer.sv | 148 ++++++++++++++
 tb/tb_exposure_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exposure_sequencer.sv
// Camera exposure sequencer: shutter open, timer load/blanking, shutter close, readout handshake.
// Optional flash trigger output is built when `EXPSEQ_FLASH_EN is defined.
module exposure_sequencer #(
    parameter int          WIDTH     = 16,
    parameter logic [15:0] OPEN_DLY  = 16'd64,
    parameter logic [15:0] CLOSE_DLY = 16'd128,
    parameter logic [15:0] FLASH_LEN = 16'd32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] exp_time,
    input  logic             abort,
    output logic             busy,
    output logic             shutter_open,
    output logic             tmr_load,
    output logic [WIDTH-1:0] tmr_preset,
    input  logic             tmr_done,
    output logic             ro_req,
    input  logic             ro_ack,
    output logic             frame_done,
`ifdef EXPSEQ_FLASH_EN
    output logic             aborted,
    output logic             flash
`else
    output logic             aborted
`endif
);

    typedef enum logic [2:0] {IDLE, PREOPEN, EXPOSE, CLOSE, READOUT} state_t;

    state_t      state;
    logic [15:0] dly_cnt;
    logic        abort_flag;
    logic        enter_expose;
    logic        leave_expose;

    if (OPEN_DLY == 16'd0) begin : g_bad_open_dly
        $error("OPEN_DLY must be at least 1");
    end
    if (CLOSE_DLY == 16'd0) begin : g_bad_close_dly
        $error("CLOSE_DLY must be at least 1");
    end
    if (FLASH_LEN == 16'd0) begin : g_bad_flash_len
        $error("FLASH_LEN must be at least 1");
    end

    // In EXPOSE the delay counter doubles as the two-cycle tmr_done blanking window.
    assign enter_expose = (state == PREOPEN) && !abort && (dly_cnt == 16'd0);
    assign leave_expose = (state == EXPOSE) && (abort || ((dly_cnt == 16'd0) && tmr_done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            dly_cnt      <= 16'd0;
            abort_flag   <= 1'b0;
            busy         <= 1'b0;
            shutter_open <= 1'b0;
            tmr_load     <= 1'b0;
            tmr_preset   <= '0;
            ro_req       <= 1'b0;
            frame_done   <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            tmr_load   <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tmr_preset   <= exp_time;
                        shutter_open <= 1'b1;
                        busy         <= 1'b1;
                        abort_flag   <= 1'b0;
                        dly_cnt      <= OPEN_DLY - 16'd1;
                        state        <= PREOPEN;
                    end
                end
                PREOPEN: begin
                    if (abort) begin
                        shutter_open <= 1'b0;
                        abort_flag   <= 1'b1;
                        dly_cnt      <= CLOSE_DLY - 16'd1;
                        state        <= CLOSE;
                    end else if (enter_expose) begin
                        tmr_load <= 1'b1;
                        dly_cnt  <= 16'd2;
                        state    <= EXPOSE;
                    end else begin
                        dly_cnt <= dly_cnt - 16'd1;
                    end
                end
                EXPOSE: begin
                    if (leave_expose) begin
                        shutter_open <= 1'b0;
                        abort_flag   <= abort;
                        dly_cnt      <= CLOSE_DLY - 16'd1;
                        state        <= CLOSE;
                    end else if (dly_cnt != 16'd0) begin
                        dly_cnt <= dly_cnt - 16'd1;
                    end
                end
                CLOSE: begin
                    if (dly_cnt != 16'd0) begin
                        dly_cnt <= dly_cnt - 16'd1;
                    end else if (abort_flag) begin
                        aborted    <= 1'b1;
                        busy       <= 1'b0;
                        abort_flag <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        ro_req <= 1'b1;
                        state  <= READOUT;
                    end
                end
                READOUT: begin
                    if (ro_ack) begin
                        ro_req     <= 1'b0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXPSEQ_FLASH_EN
    logic [15:0] flash_cnt;

    // Pulse starts with the load cycle and is cut short whenever EXPOSE ends first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash     <= 1'b0;
            flash_cnt <= 16'd0;
        end else if (enter_expose) begin
            flash     <= 1'b1;
            flash_cnt <= FLASH_LEN - 16'd1;
        end else if (leave_expose || (state != EXPOSE) || (flash_cnt == 16'd0)) begin
            flash <= 1'b0;
        end else begin
            flash_cnt <= flash_cnt - 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exposure_sequencer.sv
// Self-checking bench for exposure_sequencer: timer/readout models plus event-time scoreboard.
module tb_exposure_sequencer;

    localparam int WIDTH = 16;
    localparam int OD    = 4;
    localparam int CD    = 8;
    localparam int FL    = 32;
    localparam int TICK  = 1876;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] exp_time = '0;
    logic             ro_ack = 1'b0;
    logic             tmr_done;
    logic             busy, shutter_open, tmr_load, ro_req, frame_done, aborted;
    logic [WIDTH-1:0] tmr_preset;
`ifdef EXPSEQ_FLASH_EN
    logic             flash;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // environment controls: tmode 0 = timer model, 1 = forced done; ack_mode 0 = respond, 1 = stuck high, 2 = never
    logic done_force = 1'b0;
    int   tmode = 0;
    int   ack_mode = 0;
    int   ack_dly = 3;
    int   rq_cnt = 0;

    exposure_sequencer #(
        .WIDTH(WIDTH), .OPEN_DLY(16'(OD)), .CLOSE_DLY(16'(CD)), .FLASH_LEN(16'(FL))
    ) dut (
        .clk(clk), .rst(rst), .start(start), .exp_time(exp_time), .abort(abort),
        .busy(busy), .shutter_open(shutter_open), .tmr_load(tmr_load),
        .tmr_preset(tmr_preset), .tmr_done(tmr_done), .ro_req(ro_req), .ro_ack(ro_ack),
        .frame_done(frame_done),
`ifdef EXPSEQ_FLASH_EN
        .flash(flash),
`endif
        .aborted(aborted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // exposure timer: done clears only on load, one count per TICK clocks, sticky when expired
    logic [WIDTH-1:0] t_cnt;
    int               t_pre;
    logic             t_done;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_cnt <= '0; t_pre <= 0; t_done <= 1'b0;
        end else if (tmr_load) begin
            t_cnt <= tmr_preset; t_pre <= 0; t_done <= 1'b0;
        end else if (!t_done) begin
            if (t_cnt == '0) t_done <= 1'b1;
            else if (t_pre == TICK - 1) begin t_pre <= 0; t_cnt <= t_cnt - 1'b1; end
            else t_pre <= t_pre + 1;
        end
    end
    assign tmr_done = (tmode != 0) ? done_force : t_done;

    // readout engine
    always @(negedge clk) begin
        if (ack_mode == 1) ro_ack = 1'b1;
        else if (ro_ack) begin ro_ack = 1'b0; rq_cnt = 0; end
        else if (ack_mode == 0 && ro_req) begin
            rq_cnt = rq_cnt + 1;
            if (rq_cnt >= ack_dly) ro_ack = 1'b1;
        end else rq_cnt = 0;
    end

    int   n_load = 0, n_fd = 0, n_ab = 0, n_req = 0, n_fl = 0;
    logic req_q = 1'b0;
    always @(negedge clk) begin
        if (tmr_load) n_load = n_load + 1;
        if (frame_done) n_fd = n_fd + 1;
        if (aborted) n_ab = n_ab + 1;
        if (ro_req && !req_q) n_req = n_req + 1;
        req_q = ro_req;
`ifdef EXPSEQ_FLASH_EN
        if (flash) n_fl = n_fl + 1;
`endif
    end

    function automatic logic ev(input int which);
        case (which)
            0: return tmr_load;
            1: return !shutter_open;
            2: return ro_req;
            3: return frame_done;
            4: return aborted;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_ev(input int which, input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ev(which)) begin t = cyc; break; end
        end
    endtask

    task automatic start_frame(input logic [WIDTH-1:0] e, output int n);
        @(negedge clk); start = 1'b1; exp_time = e;
        @(negedge clk); start = 1'b0; n = cyc;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, shutter_open, tmr_load, ro_req, frame_done, aborted} !== 6'b0 || tmr_preset !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy/shut/load/req/fd/ab=%b preset=%0d, required all 0",
                     {busy, shutter_open, tmr_load, ro_req, frame_done, aborted}, tmr_preset);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_normal_frame();
        int n, l, m, r, a, ld0, fd0, ab0, fl0, len;
        tmode = 0; ack_mode = 0; ack_dly = 3;
        ld0 = n_load; fd0 = n_fd; ab0 = n_ab; fl0 = n_fl;
        start_frame(16'd2, n);
        checks++;
        if (shutter_open !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL start_accept: shutter=%b busy=%b, required 1 1", shutter_open, busy);
        end
        wait_ev(0, OD + 2, l);
        checks++;
        if (l !== n + OD) begin errors++; $display("FAIL load_time: got %0d, required %0d", l, n + OD); end
        checks++;
        if (tmr_preset !== 16'd2) begin errors++; $display("FAIL preset: got %0d, required 2", tmr_preset); end
        wait_ev(1, 3 * TICK, m);
        len = OD + 2 + 2 * TICK;
        checks++;
        if (m < 0 || (m - n) < len - 1 || (m - n) > len + 1) begin
            errors++; $display("FAIL shutter_len: got %0d, required %0d +-1", m - n, len);
        end
        wait_ev(2, CD + 2, r);
        checks++;
        if (r !== m + CD) begin errors++; $display("FAIL req_time: got %0d, required %0d", r, m + CD); end
        wait_ev(3, 10, a);
        checks++;
        if (a !== r + 3) begin errors++; $display("FAIL done_time: got %0d, required %0d", a, r + 3); end
        @(negedge clk);
        checks++;
        if ({frame_done, busy, ro_req} !== 3'b0) begin
            errors++; $display("FAIL after_frame: fd/busy/req=%b, required 000", {frame_done, busy, ro_req});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_load - ld0 != 1 || n_fd - fd0 != 1 || n_ab != ab0) begin
            errors++; $display("FAIL pulse_counts: load=%0d fd=%0d ab=%0d, required 1 1 0",
                               n_load - ld0, n_fd - fd0, n_ab - ab0);
        end
`ifdef EXPSEQ_FLASH_EN
        checks++;
        if (n_fl - fl0 != FL) begin errors++; $display("FAIL flash_len: got %0d, required %0d", n_fl - fl0, FL); end
`endif
    endtask

    task automatic test_zero_exposure();
        int n, l, m, a, fl0;
        tmode = 1; done_force = 1'b1; ack_mode = 0; ack_dly = 1;
        fl0 = n_fl;
        start_frame(16'd0, n);
        wait_ev(0, OD + 2, l);
        checks++;
        if (tmr_preset !== 16'd0) begin errors++; $display("FAIL zero_preset: got %0d, required 0", tmr_preset); end
        wait_ev(1, 20, m);
        checks++;
        if (l < 0 || m - l !== 3) begin errors++; $display("FAIL zero_expose_len: got %0d, required 3", m - l); end
        wait_ev(3, CD + 10, a);
        checks++;
        if (a < 0) begin errors++; $display("FAIL zero_frame_done: timeout, required a frame_done pulse"); end
`ifdef EXPSEQ_FLASH_EN
        checks++;
        if (n_fl - fl0 != 3) begin errors++; $display("FAIL zero_flash_len: got %0d, required 3", n_fl - fl0); end
`endif
    endtask

    task automatic test_abort_preopen();
        int n, k, b, t, ld0, rq0, ab0;
        tmode = 1; done_force = 1'b0; ack_mode = 0; ack_dly = 1;
        ld0 = n_load; rq0 = n_req; ab0 = n_ab;
        start_frame(16'($urandom_range(1, 100)), n);
        k = $urandom_range(0, OD - 2);
        repeat (k) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; b = cyc;
        checks++;
        if (shutter_open !== 1'b0) begin errors++; $display("FAIL preopen_abort_shutter: got %b, required 0", shutter_open); end
        wait_ev(4, CD + 4, t);
        checks++;
        if (t !== b + CD || busy !== 1'b0) begin
            errors++; $display("FAIL preopen_aborted: at %0d busy=%b, required %0d busy=0", t, busy, b + CD);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_load != ld0 || n_req != rq0 || n_ab - ab0 != 1) begin
            errors++; $display("FAIL preopen_counts: load=%0d req=%0d ab=%0d, required 0 0 1",
                               n_load - ld0, n_req - rq0, n_ab - ab0);
        end
    endtask

    task automatic test_abort_expose();
        int n, l, b, t, rq0, fd0, ab0;
        tmode = 0; ack_mode = 1;
        rq0 = n_req; fd0 = n_fd; ab0 = n_ab;
        start_frame(16'($urandom_range(1, 3)), n);
        wait_ev(0, OD + 2, l);
        repeat (9) @(negedge clk);
        checks++;
        if (shutter_open !== 1'b1) begin errors++; $display("FAIL expose_pre_abort: shutter=%b, required 1", shutter_open); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; b = cyc;
        checks++;
        if (shutter_open !== 1'b0) begin errors++; $display("FAIL expose_abort_shutter: got %b, required 0", shutter_open); end
        wait_ev(4, CD + 4, t);
        checks++;
        if (t !== b + CD) begin errors++; $display("FAIL expose_aborted: got %0d, required %0d", t, b + CD); end
        repeat (3) @(negedge clk);
        checks++;
        if (n_req != rq0 || n_fd != fd0 || n_ab - ab0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL expose_abort_counts: req=%0d fd=%0d ab=%0d busy=%b, required 0 0 1 0",
                               n_req - rq0, n_fd - fd0, n_ab - ab0, busy);
        end
        ack_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_abort_and_done();
        int n, l, k, b, t, rq0, fd0;
        tmode = 1; done_force = 1'b0; ack_mode = 0; ack_dly = 1;
        rq0 = n_req; fd0 = n_fd;
        start_frame(16'($urandom_range(0, 500)), n);
        wait_ev(0, OD + 2, l);
        k = $urandom_range(3, 6);
        repeat (k - 1) @(negedge clk);
        abort = 1'b1; done_force = 1'b1;
        @(negedge clk); abort = 1'b0; b = cyc;
        checks++;
        if (shutter_open !== 1'b0) begin errors++; $display("FAIL both_shutter: got %b, required 0", shutter_open); end
        wait_ev(4, CD + 4, t);
        checks++;
        if (t !== b + CD) begin errors++; $display("FAIL both_aborted: got %0d, required %0d", t, b + CD); end
        repeat (3) @(negedge clk);
        checks++;
        if (n_req != rq0 || n_fd != fd0) begin
            errors++; $display("FAIL both_no_readout: req=%0d fd=%0d, required 0 0", n_req - rq0, n_fd - fd0);
        end
    endtask

    task automatic test_random_frames();
        int n, l, m, r, a, d, exp_m;
        logic [WIDTH-1:0] e;
        tmode = 1; ack_mode = 0;
        for (int f = 0; f < 4; f++) begin
            e = 16'($urandom_range(0, 65535));
            d = $urandom_range(0, 8);
            ack_dly = $urandom_range(1, 5);
            done_force = 1'b0;
            start_frame(e, n);
            wait_ev(0, OD + 2, l);
            checks++;
            if (l !== n + OD || tmr_preset !== e) begin
                errors++; $display("FAIL rand_load: at %0d preset %0d, required %0d preset %0d", l, tmr_preset, n + OD, e);
            end
            repeat (d) @(negedge clk);
            done_force = 1'b1;
            exp_m = l + ((d + 1 > 3) ? d + 1 : 3);
            wait_ev(1, 20, m);
            checks++;
            if (m !== exp_m) begin errors++; $display("FAIL rand_close: got %0d, required %0d", m, exp_m); end
            wait_ev(2, CD + 2, r);
            wait_ev(3, ack_dly + 3, a);
            checks++;
            if (r !== m + CD || a !== r + ack_dly) begin
                errors++; $display("FAIL rand_readout: req %0d done %0d, required %0d %0d", r, a, m + CD, m + CD + ack_dly);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, l1, l2, a1, a2, ld0;
        logic [WIDTH-1:0] e1, e2;
        tmode = 1; done_force = 1'b1; ack_mode = 0; ack_dly = 1;
        e1 = 16'($urandom_range(0, 65535));
        e2 = e1 ^ 16'h5a5a;
        ld0 = n_load;
        @(negedge clk); start = 1'b1; exp_time = e1;
        @(negedge clk); n = cyc;
        wait_ev(0, OD + 2, l1);
        exp_time = e2;
        wait_ev(3, CD + 20, a1);
        checks++;
        if (a1 < 0 || tmr_preset !== e1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_first: preset %0d busy %b, required %0d 0", tmr_preset, busy, e1);
        end
        @(negedge clk);
        checks++;
        if (shutter_open !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart: shutter=%b busy=%b, required 1 1", shutter_open, busy);
        end
        start = 1'b0;
        wait_ev(0, OD + 2, l2);
        checks++;
        if (l2 !== a1 + 1 + OD || tmr_preset !== e2) begin
            errors++; $display("FAIL b2b_second: load %0d preset %0d, required %0d %0d", l2, tmr_preset, a1 + 1 + OD, e2);
        end
        wait_ev(3, CD + 20, a2);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_load - ld0 != 2) begin
            errors++; $display("FAIL b2b_end: busy=%b loads=%0d, required 0 2", busy, n_load - ld0);
        end
    endtask

    task automatic test_reset_readout();
        int n, r, a;
        logic outs;
        tmode = 1; done_force = 1'b1; ack_mode = 2;
        start_frame(16'hBEEF, n);
        wait_ev(2, OD + CD + 10, r);
        #2 rst = 1'b1;
        #1;
        outs = busy | shutter_open | tmr_load | ro_req | frame_done | aborted | (|tmr_preset);
`ifdef EXPSEQ_FLASH_EN
        outs = outs | flash;
`endif
        checks++;
        if (r < 0 || outs !== 1'b0) begin
            errors++; $display("FAIL async_reset: req seen at %0d, any output high=%b, required 0", r, outs);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, ro_req, aborted} !== 3'b0) begin
            errors++; $display("FAIL reset_idle_after: busy/req/ab=%b, required 000", {busy, ro_req, aborted});
        end
        ack_mode = 0; ack_dly = 1;
        start_frame(16'd5, n);
        checks++;
        if (shutter_open !== 1'b1 || tmr_preset !== 16'd5) begin
            errors++; $display("FAIL reset_restart: shutter=%b preset=%0d, required 1 5", shutter_open, tmr_preset);
        end
        wait_ev(3, OD + CD + 20, a);
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_zero_exposure();
        test_abort_preopen();
        test_abort_expose();
        test_abort_and_done();
        test_random_frames();
        test_back_to_back();
        test_reset_readout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
